msix_pba_engine: RTL and testbench

- Parametrised MSI-X Pending Bit Array engine for the PCIe endpoint register/interrupt path.
- Holds the programmable PBA Offset/BIR capability register and one pending bit per vector.
- Accepts per-vector interrupt events, applies vector, function and enable masking, and round-robin arbitrates unmasked pending vectors into a req/ack message interface.
- Exposes the PBA as QWORD-readable data for the BAR read path.

---
 rtl/msix_pba_if.sv | 22 ++
 rtl/msix_pba_engine.sv | 130 +++++++++++++
 tb/tb_msix_pba_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/msix_pba_if.sv
// MSI-X message request/ack handshake and PBA QWORD read bus.
interface msix_pba_if #(
    parameter int QA_W = 1
);
    logic            msg_req;
    logic [10:0]     msg_vector;
    logic            msg_ack;
    logic            pba_rd_en;
    logic [QA_W-1:0] pba_rd_addr;
    logic [63:0]     pba_rd_data;
    logic            pba_rd_valid;

    // master: the PBA engine; slave: TLP generator plus BAR read path
    modport master (
        output msg_req, msg_vector, pba_rd_data, pba_rd_valid,
        input  msg_ack, pba_rd_en, pba_rd_addr
    );
    modport slave (
        input  msg_req, msg_vector, pba_rd_data, pba_rd_valid,
        output msg_ack, pba_rd_en, pba_rd_addr
    );
endinterface

// File: rtl/msix_pba_engine.sv
// MSI-X Pending Bit Array: Offset/BIR register, per-vector pending bits,
// round-robin message arbitration and QWORD-readable PBA.
module msix_pba_engine #(
    parameter int          NUM_VECTORS  = 32,
    parameter logic [28:0] RESET_OFFSET = 29'h0,
    parameter logic [2:0]  RESET_BIR    = 3'd0,
    localparam int         QW           = (NUM_VECTORS + 63) / 64,
    localparam int         QA_W         = (QW > 1) ? $clog2(QW) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            cfg_write_data,
    input  logic                   cfg_write_enable,
    output logic [31:0]            cfg_read_data,
    input  logic                   msix_enable,
    input  logic                   function_mask,
    input  logic [NUM_VECTORS-1:0] vec_mask,
    input  logic [NUM_VECTORS-1:0] vec_event,
    msix_pba_if.master             bus,
    output logic                   pending_any
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [10:0] LAST_VEC = 11'(NUM_VECTORS - 1);

    state_t                 state, state_nxt;
    logic [NUM_VECTORS-1:0] pending, pending_nxt, eligible;
    logic [10:0]            ptr, ptr_nxt, vec_nxt, sel_idx, hi_idx, lo_idx;
    logic                   req_nxt, clr, hi_found, lo_found;
    logic [QW*64-1:0]       pend_pad;
    logic [63:0]            rd_word;
    logic [QA_W-1:0]        rd_addr;

    assign rd_addr  = bus.pba_rd_addr;
    assign eligible = pending & ~vec_mask & {NUM_VECTORS{msix_enable & ~function_mask}};

    // Downward scan so the lowest index wins; hi_* covers the range at/above ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_found = 1'b1;
                lo_idx   = 11'(i);
                if (11'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = 11'(i);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = bus.msg_req;
        vec_nxt   = bus.msg_vector;
        ptr_nxt   = ptr;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (lo_found) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    vec_nxt   = sel_idx;
                end
            end
            REQ: begin
                if (bus.msg_ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    clr       = 1'b1;
                    ptr_nxt   = (bus.msg_vector == LAST_VEC) ? 11'd0 : bus.msg_vector + 11'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear applied before set so an event coinciding with its own ack survives.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            if (clr && bus.msg_vector == 11'(i)) pending_nxt[i] = 1'b0;
        end
        if (msix_enable) pending_nxt = pending_nxt | vec_event;
    end

    always_comb begin
        pend_pad                  = '0;
        pend_pad[NUM_VECTORS-1:0] = pending;
        rd_word                   = '0;
        for (int q = 0; q < QW; q++) begin
            if (int'(rd_addr) == q) rd_word = pend_pad[q*64 +: 64];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending          <= '0;
            ptr              <= '0;
            bus.msg_req      <= 1'b0;
            bus.msg_vector   <= '0;
            bus.pba_rd_data  <= '0;
            bus.pba_rd_valid <= 1'b0;
            pending_any      <= 1'b0;
            cfg_read_data    <= {RESET_OFFSET, RESET_BIR};
        end else begin
            pending          <= pending_nxt;
            ptr              <= ptr_nxt;
            bus.msg_req      <= req_nxt;
            bus.msg_vector   <= vec_nxt;
            bus.pba_rd_valid <= bus.pba_rd_en;
            pending_any      <= |pending;
            if (bus.pba_rd_en) bus.pba_rd_data <= rd_word;
            if (cfg_write_enable) begin
                cfg_read_data[31:3] <= cfg_write_data[31:3];
                // BIR encodings 6 and 7 are reserved and leave the field untouched
                if (cfg_write_data[2:0] <= 3'd5) cfg_read_data[2:0] <= cfg_write_data[2:0];
            end
        end
    end
endmodule

// File: tb/tb_msix_pba_engine.sv
// Directed bench for msix_pba_engine: a 32-vector instance and a 70-vector instance.
module tb_msix_pba_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] cfg_wd, cfg_rd, cfg_rd70;
    logic        cfg_we, en, fmask, pany, pany70;
    logic [31:0] vmask, vev;
    logic [69:0] vev70;
    int          checks = 0;
    int          errors = 0;

    msix_pba_if #(.QA_W(1)) bus ();
    msix_pba_if #(.QA_W(1)) bus70 ();

    msix_pba_engine #(.NUM_VECTORS(32), .RESET_OFFSET(29'h100), .RESET_BIR(3'd2)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_write_data(cfg_wd), .cfg_write_enable(cfg_we), .cfg_read_data(cfg_rd),
        .msix_enable(en), .function_mask(fmask), .vec_mask(vmask), .vec_event(vev),
        .bus(bus.master), .pending_any(pany)
    );

    msix_pba_engine #(.NUM_VECTORS(70)) u_dut70 (
        .clk(clk), .reset_n(reset_n),
        .cfg_write_data(32'h0), .cfg_write_enable(1'b0), .cfg_read_data(cfg_rd70),
        .msix_enable(1'b1), .function_mask(1'b1), .vec_mask(70'h0), .vec_event(vev70),
        .bus(bus70.master), .pending_any(pany70)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic a, input logic [63:0] exp, input string tag);
        bus.pba_rd_en   = 1'b1;
        bus.pba_rd_addr = a;
        tick();
        bus.pba_rd_en   = 1'b0;
        check(tag, bus.pba_rd_data, exp);
        check("rd_valid", {63'h0, bus.pba_rd_valid}, 64'h1);
    endtask

    task automatic rd70(input logic a, input logic [63:0] exp, input string tag);
        bus70.pba_rd_en   = 1'b1;
        bus70.pba_rd_addr = a;
        tick();
        bus70.pba_rd_en   = 1'b0;
        check(tag, bus70.pba_rd_data, exp);
        check("rd70_valid", {63'h0, bus70.pba_rd_valid}, 64'h1);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!bus.msg_req && n < budget) begin
            tick();
            n++;
        end
        check("req_seen", {63'h0, bus.msg_req}, 64'h1);
    endtask

    task automatic serve(input logic [10:0] v, input logic [31:0] inj);
        wait_req(20);
        check("served_vec", {53'h0, bus.msg_vector}, {53'h0, v});
        vev         = inj;
        bus.msg_ack = 1'b1;
        tick();
        vev         = '0;
        bus.msg_ack = 1'b0;
        check("req_drop", {63'h0, bus.msg_req}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; cfg_wd = '0; cfg_we = 1'b0; en = 1'b0; fmask = 1'b0;
        vmask = '0; vev = '0; vev70 = '0;
        bus.msg_ack = 1'b0; bus.pba_rd_en = 1'b0; bus.pba_rd_addr = '0;
        bus70.msg_ack = 1'b0; bus70.pba_rd_en = 1'b0; bus70.pba_rd_addr = '0;
        tick(); tick();
        check("rst_cfg", {32'h0, cfg_rd}, 64'h802);
        check("rst_req", {63'h0, bus.msg_req}, 64'h0);
        check("rst_vec", {53'h0, bus.msg_vector}, 64'h0);
        check("rst_rdata", bus.pba_rd_data, 64'h0);
        check("rst_rvalid", {63'h0, bus.pba_rd_valid}, 64'h0);
        check("rst_pany", {63'h0, pany}, 64'h0);
        check("rst_cfg70", {32'h0, cfg_rd70}, 64'h0);
        reset_n = 1'b1;
        tick();

        cfg_wd = 32'h0000_1007; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        check("cfg_rsvd_bir", {32'h0, cfg_rd}, 64'h1002);
        cfg_wd = 32'h0000_1004; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        check("cfg_bir4", {32'h0, cfg_rd}, 64'h1004);

        en = 1'b1; vmask = 32'h20; vev = 32'h20; tick(); vev = '0; tick();
        check("masked_noreq", {63'h0, bus.msg_req}, 64'h0);
        check("pany_set", {63'h0, pany}, 64'h1);
        rd(1'b0, 64'h20, "pba_masked");
        tick();
        check("rd_valid_pulse", {63'h0, bus.pba_rd_valid}, 64'h0);
        rd(1'b1, 64'h0, "pba_out_of_range");

        en = 1'b0; vev = 32'h4; tick(); vev = '0;
        rd(1'b0, 64'h20, "en_off_drop_keep");

        en = 1'b1; fmask = 1'b1; vmask = '0; tick(); tick();
        check("fmask_noreq", {63'h0, bus.msg_req}, 64'h0);
        fmask = 1'b0; tick();
        check("unmask_req", {63'h0, bus.msg_req}, 64'h1);
        check("unmask_vec", {53'h0, bus.msg_vector}, 64'h5);
        vmask = 32'h20; cfg_wd = 32'h0; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        check("req_held", {63'h0, bus.msg_req}, 64'h1);
        check("vec_held", {53'h0, bus.msg_vector}, 64'h5);
        vmask = '0;
        serve(11'd5, 32'h0);
        rd(1'b0, 64'h0, "pba_cleared");
        tick();
        check("pany_clr", {63'h0, pany}, 64'h0);

        vmask = 32'h20; vev = 32'h20; tick(); vev = '0;
        bus.msg_ack = 1'b1; tick(); bus.msg_ack = 1'b0;
        rd(1'b0, 64'h20, "ack_idle_ignored");

        vmask = '0;
        wait_req(10);
        reset_n = 1'b0; tick();
        check("rst_mid_req", {63'h0, bus.msg_req}, 64'h0);
        check("rst_mid_cfg", {32'h0, cfg_rd}, 64'h802);
        reset_n = 1'b1; tick();
        rd(1'b0, 64'h0, "rst_pending_lost");
        tick();
        check("rst_noreq", {63'h0, bus.msg_req}, 64'h0);

        vev = 32'h4000_0088; tick(); vev = '0;
        serve(11'd3, 32'h0);
        serve(11'd7, 32'h8);
        serve(11'd30, 32'h0);
        serve(11'd3, 32'h8);
        serve(11'd3, 32'h0);
        repeat (4) tick();
        check("rr_done_noreq", {63'h0, bus.msg_req}, 64'h0);
        check("rr_done_pany", {63'h0, pany}, 64'h0);

        vev70 = 70'd1 << 69; tick(); vev70 = '0;
        rd70(1'b1, 64'h20, "pba70_qw1");
        rd70(1'b0, 64'h0, "pba70_qw0");
        check("pany70", {63'h0, pany70}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
